uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Transmit serializer directly downstream of the UART register decode block. It consumes the decoded transmit byte, the parity-enable bit and the start-request level, and shifts out a standard asynchronous frame on the serial line. Frame order is start bit, 8 data bits LSB first, optional parity bit, then one stop bit. It returns tx_send (busy) and tx_done, which feed the decode block's Tx status register.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range is 2 or more.
PARITY_ODD, 0, 0 = even parity bit (^data), 1 = odd parity bit (~^data).

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
Tx_Data  input  8  byte to transmit; sampled only at frame acceptance.
Parity  input  1  1 = insert parity bit after data; sampled at acceptance.
Tx_Start  input  1  start-request level; a frame is requested on its rising edge.
tx  output  1  serial line; idles high.
tx_send  output  1  high while a frame is in flight.
tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: tx=1, tx_send=0, tx_done=0, state=IDLE, bit counter=0, baud counter=0, start_d=1.
- start_d resets to 1, so a Tx_Start held high through reset does not launch a frame.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Edge detect: start_d <= Tx_Start every cycle. rise = Tx_Start & ~start_d.
- start_d updates in every state, so a rising edge that occurs while busy is discarded, not queued.
- State machine states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - On rise, latch Tx_Data into the shift register and latch Parity into par_en.
  - Compute par_bit = (^Tx_Data) ^ PARITY_ODD.
  - Go to START. tx=0 and tx_send=1 from the next cycle.
  - tx_done is cleared in every cycle it is not pulsed.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Drive shift[0]. Shift right every CLKS_PER_BIT cycles.
  - After the 8th bit, go to PAR if par_en, else STOP.
- PAR: drive par_bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: drive tx=1 for CLKS_PER_BIT cycles, then:
  - Go to IDLE.
  - tx_send=0 and tx_done=1 for exactly one cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 at each bit boundary.
  - Its width is clog2(CLKS_PER_BIT).
  - It is cleared on acceptance.
- Frame length: tx_send is high for exactly 10*CLKS_PER_BIT cycles without parity, or 11*CLKS_PER_BIT with parity.
- Back-to-back frames: a rise seen in the tx_done cycle (state IDLE) is accepted. tx goes low on the next cycle, so there is no extra idle bit.
- Input stability: Tx_Data and Parity changes after acceptance have no effect on the frame in flight.
- Reset mid-frame: on the next edge tx=1, tx_send=0 and state=IDLE. No tx_done pulse is produced.
- Simultaneous reset and rise: reset wins and no frame starts.

Test Plan:
1. Setup: CLKS_PER_BIT=4, Parity=0, Tx_Data=0x55, pulse Tx_Start 0->1. Required response:
   - tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
   - tx_send high 40 cycles.
   - tx_done=1 in cycle 41 only.
2. Setup: Parity=1, Tx_Data=0xA7. Required response:
   - data bits 1,1,1,0,0,1,0,1.
   - parity bit 1 (five ones, even).
   - stop bit 1.
   - tx_send high 44 cycles.
   - Repeat with PARITY_ODD=1: parity bit 0.
3. Hold Tx_Start high across two frame times, then toggle it 0->1 mid-frame. Required response: exactly one frame; the mid-frame edge is ignored; tx stays 1 afterwards.
4. Change Tx_Data from 0x55 to 0xFF during DATA bit 2. Required response: the serialized frame still matches 0x55.
5. Assert reset for 1 cycle during DATA bit 3. Required response:
   - next cycle tx=1 and tx_send=0; tx_done never pulses.
   - a following request with 0x3C produces a correct full frame.
6. Raise Tx_Start in the tx_done cycle with Tx_Data=0x0F. Required response: tx=0 in the very next cycle, and the second frame is bit-exact.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity, one stop bit.
// All outputs registered; tx_send is busy, tx_done is a one-cycle completion pulse.
//
// state   | meaning
// S_IDLE  | line high, waiting for a rising edge on Tx_Start
// S_START | driving the start bit (0)
// S_DATA  | driving shift_q[0], shifting right at every bit boundary
// S_PAR   | driving the latched parity bit
// S_STOP  | driving the stop bit (1); completion pulse on exit
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_Data,
  input  logic       Parity,
  input  logic       Tx_Start,
  output logic       tx,
  output logic       tx_send,
  output logic       tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t state_q, state_d;

  logic [CW-1:0] baud_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_en_q, par_bit_q;
  logic          start_q;
  logic          tx_q, tx_d;
  logic          send_q, send_d;
  logic          done_q, done_d;

  logic rise, bit_end, accept;

  assign rise    = Tx_Start & ~start_q;
  assign bit_end = (baud_q == LAST);
  assign accept  = (state_q == S_IDLE) & rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (rise) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && bit_cnt_q == 3'd7) state_d = par_en_q ? S_PAR : S_STOP;
      S_PAR:   if (bit_end) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are the next-cycle values; they are registered below.
  always_comb begin
    tx_d   = 1'b1;
    send_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && bit_end;
    unique case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = (state_q == S_DATA && bit_end) ? shift_q[1] : shift_q[0];
      S_PAR:   tx_d = par_bit_q;
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= 1'b1;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      send_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_q <= Tx_Start;
      tx_q    <= tx_d;
      send_q  <= send_d;
      done_q  <= done_d;

      if (state_q == S_IDLE || bit_end) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + CW'(1);
      end

      if (accept) begin
        shift_q   <= Tx_Data;
        par_en_q  <= Parity;
        par_bit_q <= (^Tx_Data) ^ ODD_BIT;
        bit_cnt_q <= '0;
      end else if (state_q == S_DATA && bit_end) begin
        shift_q   <= shift_q >> 1;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

  assign tx      = tx_q;
  assign tx_send = send_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a frame-level queue model checked every cycle against
// an even-parity and an odd-parity instance, plus literal frame/length expectations.
module tb_uart_tx_serializer;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Tx_Data;
  logic       Parity;
  logic       Tx_Start;
  logic       tx_e, send_e, done_e;
  logic       tx_o, send_o, done_o;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_ODD(0)) u_even (
    .clk(clk), .reset(reset), .Tx_Data(Tx_Data), .Parity(Parity), .Tx_Start(Tx_Start),
    .tx(tx_e), .tx_send(send_e), .tx_done(done_e));

  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .Tx_Data(Tx_Data), .Parity(Parity), .Tx_Start(Tx_Start),
    .tx(tx_o), .tx_send(send_o), .tx_done(done_o));

  // Model: each accepted request expands into the full per-cycle output list.
  typedef struct packed {
    logic tx_e;
    logic tx_o;
    logic send;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   m_prev;
  bit   model_valid = 1'b0;

  function automatic exp_t mk(input logic te, input logic to, input logic s, input logic d);
    exp_t r;
    r.tx_e = te;
    r.tx_o = to;
    r.send = s;
    r.done = d;
    return r;
  endfunction

  function automatic void build_frame(input logic [7:0] d, input logic p_en);
    logic [10:0] be, bo;
    int n;
    be = '1;
    bo = '1;
    be[0] = 1'b0;
    bo[0] = 1'b0;
    be[8:1] = d;
    bo[8:1] = d;
    n = 10;
    if (p_en) begin
      be[9] = ^d;
      bo[9] = ~^d;
      n = 11;
    end
    for (int b = 0; b < n; b++)
      for (int c = 0; c < C; c++)
        exp_q.push_back(mk(1'(be >> b), 1'(bo >> b), 1'b1, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_prev = 1'b1;
      cur = mk(1'b1, 1'b1, 1'b0, 1'b0);
      model_valid = 1'b1;
    end else begin
      if (exp_q.size() == 0 && Tx_Start && !m_prev) build_frame(Tx_Data, Parity);
      m_prev = Tx_Start;
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = mk(1'b1, 1'b1, 1'b0, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      logic [5:0] act, req;
      act = {tx_e, tx_o, send_e, done_e, send_o, done_o};
      req = {cur.tx_e, cur.tx_o, cur.send, cur.done, cur.send, cur.done};
      tests++;
      if (act !== req) begin
        errors++;
        $display("FAIL cycle_model t=%0t: {tx_e,tx_o,send_e,done_e,send_o,done_o} got %b expected %b",
                 $time, act, req);
      end
    end
  end

  // Frame monitor: length of tx_send and the mid-bit samples of each completed frame.
  int          send_len = 0;
  int          frames_done = 0;
  int          last_len = 0;
  logic [10:0] cap_e = '0, cap_o = '0, last_e = '0, last_o = '0;

  always @(negedge clk) begin
    if (done_e === 1'b1) begin
      last_len = send_len;
      last_e = cap_e;
      last_o = cap_o;
      frames_done++;
      send_len = 0;
      cap_e = '0;
      cap_o = '0;
    end else if (send_e !== 1'b1) begin
      send_len = 0;
      cap_e = '0;
      cap_o = '0;
    end else begin
      if (send_len % C == C / 2 && send_len / C < 11) begin
        cap_e = cap_e | (11'(tx_e) << (send_len / C));
        cap_o = cap_o | (11'(tx_o) << (send_len / C));
      end
      send_len++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_frame(input string name, input int budget);
    int n0;
    bit seen;
    n0 = frames_done;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (frames_done != n0) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: got no tx_done within %0d cycles expected a completed frame", name, budget);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    Tx_Data = d;
    Parity = p;
    Tx_Start = 1'b1;
    tick(1);
    Tx_Start = 1'b0;
  endtask

  initial begin
    int n0;
    bit seen;
    reset = 1'b1;
    Tx_Start = 1'b0;
    Tx_Data = 8'h00;
    Parity = 1'b0;
    tick(3);
    check("reset_tx", 32'(tx_e), 32'd1);
    check("reset_send", 32'(send_e), 32'd0);
    check("reset_done", 32'(done_e), 32'd0);

    // Tx_Start already high when reset releases: no frame
    Tx_Start = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(12);
    check("held_through_reset_send", 32'(send_e), 32'd0);
    check("held_through_reset_frames", 32'(frames_done), 32'd0);
    Tx_Start = 1'b0;
    tick(2);

    // 0x55, no parity
    send_frame(8'h55, 1'b0);
    wait_frame("t1_frame", 100);
    check("t1_len", 32'(last_len), 32'd40);
    check("t1_bits_even", 32'(last_e), 32'h2AA);
    check("t1_bits_odd", 32'(last_o), 32'h2AA);
    tick(3);

    // 0xA7 with parity: even bit 1, odd bit 0
    send_frame(8'hA7, 1'b1);
    wait_frame("t2_frame", 100);
    check("t2_len", 32'(last_len), 32'd44);
    check("t2_bits_even", 32'(last_e), 32'h74E);
    check("t2_bits_odd", 32'(last_o), 32'h54E);
    tick(3);

    // Start held across two frame times with a mid-frame re-edge
    Tx_Data = 8'h33;
    Parity = 1'b0;
    n0 = frames_done;
    Tx_Start = 1'b1;
    tick(15);
    Tx_Start = 1'b0;
    tick(1);
    Tx_Start = 1'b1;
    tick(75);
    check("t3_frame_count", 32'(frames_done - n0), 32'd1);
    check("t3_tx_idle", 32'(tx_e), 32'd1);
    check("t3_send_idle", 32'(send_e), 32'd0);
    Tx_Start = 1'b0;
    tick(3);

    // Inputs change during data bit 2
    send_frame(8'h55, 1'b0);
    tick(12);
    Tx_Data = 8'hFF;
    Parity = 1'b1;
    wait_frame("t4_frame", 100);
    check("t4_len", 32'(last_len), 32'd40);
    check("t4_bits_even", 32'(last_e), 32'h2AA);
    tick(3);

    // Reset pulse during data bit 3, then a clean frame
    n0 = frames_done;
    send_frame(8'h99, 1'b0);
    tick(17);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5_tx_after_reset", 32'(tx_e), 32'd1);
    check("t5_send_after_reset", 32'(send_e), 32'd0);
    tick(40);
    check("t5_no_done", 32'(frames_done - n0), 32'd0);
    send_frame(8'h3C, 1'b0);
    wait_frame("t5_frame", 100);
    check("t5_len", 32'(last_len), 32'd40);
    check("t5_bits_even", 32'(last_e), 32'h278);
    tick(3);

    // Back-to-back: request raised in the tx_done cycle
    send_frame(8'h81, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_e === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_first_done_seen", 32'(seen), 32'd1);
    Tx_Data = 8'h0F;
    Tx_Start = 1'b1;
    tick(1);
    check("t6_tx_low_next", 32'(tx_e), 32'd0);
    check("t6_send_next", 32'(send_e), 32'd1);
    Tx_Start = 1'b0;
    wait_frame("t6_frame", 100);
    check("t6_len", 32'(last_len), 32'd40);
    check("t6_bits_even", 32'(last_e), 32'h21E);
    check("t6_bits_odd", 32'(last_o), 32'h21E);
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
